// File: rtl/spi_defs.sv
// Shared definitions for the SPI slave: frame size default, FSM encodings
// and the levels the input synchronizers hold while in reset.
package spi_defs;

   localparam int FRAME_BITS_DEF  = 32;
   localparam int SYNC_STAGES_DEF = 2;

   // Idle bus levels for mode 0 with active-low chip select.
   localparam logic SCLK_IDLE = 1'b0;
   localparam logic CS_IDLE   = 1'b1;
   localparam logic MOSI_IDLE = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2
   } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input followed by a
// single-register edge detector. Reset forces the chain to the bus idle
// level so no spurious edge is seen when reset releases.
module spi_sync_edge #(
   parameter int   STAGES   = 2,
   parameter logic IDLE_LVL = 1'b0
) (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // Shift the raw input through the synchronizer and keep one delayed copy.
   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         sync_q <= {STAGES{IDLE_LVL}};
         prev_q <= IDLE_LVL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign q    = sync_q[STAGES-1];
   assign rise = sync_q[STAGES-1] & ~prev_q;
   assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI slave, oversampled on the board clock. One frame of
// FRAME_BITS bits per chip-select window; the received word is handed over
// with a done/ack level handshake, with sticky overrun and abort pulse.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | deselected, MISO tri-stated, waiting for CS falling edge
// ST_SHIFT | selected, shifting bits on SCLK edges
// ST_HOLD  | full frame received, further SCLK ignored until CS rises
module spi_slave
   import spi_defs::*;
#(
   parameter int FRAME_BITS  = FRAME_BITS_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic                  BOARD_CLOCK,
   input  logic                  RST,
   input  logic                  SPI_SCLK,
   input  logic                  SPI_MOSI,
   input  logic                  SPI_CS,
   output logic                  SPI_MISO,
   output logic                  SPI_MISO_OE,
   input  logic [FRAME_BITS-1:0] SPI_I,
   output logic [FRAME_BITS-1:0] SPI_O,
   output logic                  SPI_DONE_O,
   input  logic                  SPI_ACK_I,
   output logic                  SPI_OVR_O,
   output logic                  SPI_ABORT_O
);

   localparam int                CNT_W    = $clog2(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_BITS - 1);

   logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
   logic unused_sclk_lvl, unused_cs_lvl, unused_mosi_rise, unused_mosi_fall;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LVL(SCLK_IDLE)) u_sync_sclk (
      .clk_sys (BOARD_CLOCK),
      .rst_b   (RST),
      .d       (SPI_SCLK),
      .q       (unused_sclk_lvl),
      .rise    (sclk_rise),
      .fall    (sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LVL(CS_IDLE)) u_sync_cs (
      .clk_sys (BOARD_CLOCK),
      .rst_b   (RST),
      .d       (SPI_CS),
      .q       (unused_cs_lvl),
      .rise    (cs_rise),
      .fall    (cs_fall)
   );

   // MOSI uses the same depth as SCLK so the sampled level lines up with
   // the detected rising edge.
   spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LVL(MOSI_IDLE)) u_sync_mosi (
      .clk_sys (BOARD_CLOCK),
      .rst_b   (RST),
      .d       (SPI_MOSI),
      .q       (mosi_s),
      .rise    (unused_mosi_rise),
      .fall    (unused_mosi_fall)
   );

   spi_state_t            state_q, state_nxt;
   logic [FRAME_BITS-1:0] tx_sr, rx_sr, rx_nxt;
   logic [CNT_W-1:0]      bit_cnt;
   logic                  start_frame, rx_shift, tx_shift, frame_done, abort_nxt;

   assign rx_nxt = {rx_sr[FRAME_BITS-2:0], mosi_s};

   // State register.
   always_ff @(posedge BOARD_CLOCK or negedge RST) begin
      if (!RST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next-state and datapath strobes; a CS rise wins over a coincident SCLK edge.
   always_comb begin
      state_nxt   = state_q;
      start_frame = 1'b0;
      rx_shift    = 1'b0;
      tx_shift    = 1'b0;
      frame_done  = 1'b0;
      abort_nxt   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               state_nxt   = ST_SHIFT;
               start_frame = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (cs_rise) begin
               state_nxt = ST_IDLE;
               abort_nxt = 1'b1;
            end else if (sclk_rise) begin
               rx_shift = 1'b1;
               if (bit_cnt == CNT_LAST) begin
                  frame_done = 1'b1;
                  state_nxt  = ST_HOLD;
               end
            end else if (sclk_fall) begin
               tx_shift = 1'b1;
            end
         end
         ST_HOLD: begin
            if (cs_rise) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Shift registers, bit counter, MISO drive and the host-side handshake.
   always_ff @(posedge BOARD_CLOCK or negedge RST) begin
      if (!RST) begin
         tx_sr       <= '0;
         rx_sr       <= '0;
         bit_cnt     <= '0;
         SPI_MISO    <= 1'b0;
         SPI_MISO_OE <= 1'b0;
         SPI_O       <= '0;
         SPI_DONE_O  <= 1'b0;
         SPI_OVR_O   <= 1'b0;
         SPI_ABORT_O <= 1'b0;
      end else begin
         SPI_ABORT_O <= abort_nxt;
         SPI_MISO_OE <= (state_nxt != ST_IDLE);

         if (start_frame) begin
            tx_sr    <= SPI_I;
            rx_sr    <= '0;
            bit_cnt  <= '0;
            SPI_MISO <= SPI_I[FRAME_BITS-1];
         end

         if (rx_shift) begin
            rx_sr <= rx_nxt;
            if (bit_cnt != CNT_MAX) begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end

         if (tx_shift) begin
            tx_sr    <= tx_sr << 1;
            SPI_MISO <= tx_sr[FRAME_BITS-2];
         end

         if (frame_done || abort_nxt) begin
            SPI_MISO <= 1'b0;
         end

         // A completing frame always wins the done flag; an ACK in the same
         // cycle consumes the old word, so no overrun is recorded.
         if (frame_done) begin
            SPI_O      <= rx_nxt;
            SPI_DONE_O <= 1'b1;
            SPI_OVR_O  <= SPI_ACK_I ? 1'b0 : (SPI_OVR_O | SPI_DONE_O);
         end else if (SPI_ACK_I) begin
            SPI_DONE_O <= 1'b0;
            SPI_OVR_O  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bit-banged mode-0 master drives frames,
// expected received words go into a queue, and a monitor pops and compares
// whenever the slave presents a new word.
module tb_spi_slave;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        sclk   = 1'b0;
   logic        mosi   = 1'b0;
   logic        cs     = 1'b1;
   logic        ack    = 1'b0;
   logic [31:0] spi_i  = '0;
   logic        miso, miso_oe, spi_done, spi_ovr, spi_abort;
   logic [31:0] spi_o;

   always #12 clk = ~clk;

   spi_slave #(.FRAME_BITS(32), .SYNC_STAGES(2)) dut (
      .BOARD_CLOCK (clk),
      .RST         (rst_n),
      .SPI_SCLK    (sclk),
      .SPI_MOSI    (mosi),
      .SPI_CS      (cs),
      .SPI_MISO    (miso),
      .SPI_MISO_OE (miso_oe),
      .SPI_I       (spi_i),
      .SPI_O       (spi_o),
      .SPI_DONE_O  (spi_done),
      .SPI_ACK_I   (ack),
      .SPI_OVR_O   (spi_ovr),
      .SPI_ABORT_O (spi_abort)
   );

   int          n_checks  = 0;
   int          n_fail    = 0;
   int          abort_cnt = 0;
   int          abort_long = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: a new word shows up as DONE rising or SPI_O changing value.
   logic        done_prev  = 1'b0;
   logic        abort_prev = 1'b0;
   logic [31:0] o_prev     = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         done_prev  = 1'b0;
         abort_prev = 1'b0;
         o_prev     = '0;
      end else begin
         if ((spi_done && !done_prev) || (spi_o != o_prev)) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_word: got %h expected no new word", spi_o);
            end else begin
               check("rx_word", spi_o, exp_q.pop_front());
            end
         end
         if (spi_abort) abort_cnt++;
         if (spi_abort && abort_prev) abort_long++;
         done_prev  = spi_done;
         abort_prev = spi_abort;
         o_prev     = spi_o;
      end
   end

   // Mode-0 master: 8 board clocks per SCLK phase (~2.5 MHz at 40 MHz).
   // Bits past 32 are driven as 1 so any capture of them would corrupt SPI_O.
   task automatic xfer(input logic [31:0] tx, input int n_clk, input bit ack_last,
                       input bit release_cs, output logic [31:0] rx, output int extra_ones);
      rx = '0;
      extra_ones = 0;
      @(negedge clk);
      mosi = tx[31];
      cs   = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < n_clk; i++) begin
         if (i > 0) begin
            mosi = (i < 32) ? tx[31-i] : 1'b1;
            repeat (8) @(negedge clk);
         end
         if (i == 0) check("oe_in_frame", {31'd0, miso_oe}, 32'd1);
         if (i < 32) rx = {rx[30:0], miso};
         else if (miso) extra_ones++;
         sclk = 1'b1;
         if (ack_last && i == n_clk - 1) begin
            // Two synchronizer flops, then the edge is acted on at the third edge.
            @(posedge clk);
            @(posedge clk);
            #1 ack = 1'b1;
            @(posedge clk);
            #1 ack = 1'b0;
            repeat (6) @(negedge clk);
         end else begin
            repeat (8) @(negedge clk);
         end
         sclk = 1'b0;
      end
      repeat (8) @(negedge clk);
      if (release_cs) begin
         cs = 1'b1;
         repeat (8) @(negedge clk);
      end
   endtask

   task automatic do_ack();
      @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_spi_o"}, spi_o, 32'd0);
      check({tag, "_done"},  {31'd0, spi_done},  32'd0);
      check({tag, "_ovr"},   {31'd0, spi_ovr},   32'd0);
      check({tag, "_abort"}, {31'd0, spi_abort}, 32'd0);
      check({tag, "_miso"},  {31'd0, miso},      32'd0);
      check({tag, "_oe"},    {31'd0, miso_oe},   32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not finish, n_checks=%0d", n_checks);
      $fatal(1, "timeout");
   end

   logic [31:0] rx;
   int          extra;

   initial begin
      repeat (5) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // ACK with nothing pending changes nothing.
      do_ack();
      check("ack_noop_done", {31'd0, spi_done}, 32'd0);
      check("ack_noop_ovr",  {31'd0, spi_ovr},  32'd0);

      // Basic full-duplex frame.
      spi_i = 32'hA5C3_0F81;
      exp_q.push_back(32'h1234_5678);
      xfer(32'h1234_5678, 32, 1'b0, 1'b1, rx, extra);
      check("f1_miso_word", rx, 32'hA5C3_0F81);
      check("f1_oe_after_cs", {31'd0, miso_oe}, 32'd0);
      check("f1_done", {31'd0, spi_done}, 32'd1);
      repeat (20) @(negedge clk);
      check("f1_done_held", {31'd0, spi_done}, 32'd1);
      do_ack();
      check("f1_done_cleared", {31'd0, spi_done}, 32'd0);

      // Abort after 13 bits; previous word and flags untouched.
      spi_i = 32'hFFFF_0000;
      xfer(32'hABCD_0000, 13, 1'b0, 1'b1, rx, extra);
      check("abort_count", abort_cnt, 32'd1);
      check("abort_width", abort_long, 32'd0);
      check("abort_done", {31'd0, spi_done}, 32'd0);
      check("abort_spi_o", spi_o, 32'h1234_5678);
      spi_i = 32'h5A5A_5A5A;
      exp_q.push_back(32'h0F0F_1234);
      xfer(32'h0F0F_1234, 32, 1'b0, 1'b1, rx, extra);
      check("post_abort_miso", rx, 32'h5A5A_5A5A);
      do_ack();

      // Overrun: two frames with no ACK.
      spi_i = 32'h0;
      exp_q.push_back(32'h1111_1111);
      xfer(32'h1111_1111, 32, 1'b0, 1'b1, rx, extra);
      check("ovr_first_clear", {31'd0, spi_ovr}, 32'd0);
      exp_q.push_back(32'h2222_2222);
      xfer(32'h2222_2222, 32, 1'b0, 1'b1, rx, extra);
      check("ovr_spi_o", spi_o, 32'h2222_2222);
      check("ovr_flag", {31'd0, spi_ovr}, 32'd1);
      check("ovr_done", {31'd0, spi_done}, 32'd1);
      do_ack();
      check("ovr_ack_done", {31'd0, spi_done}, 32'd0);
      check("ovr_ack_ovr",  {31'd0, spi_ovr},  32'd0);

      // Completion in the same cycle as ACK.
      exp_q.push_back(32'h3333_3333);
      xfer(32'h3333_3333, 32, 1'b0, 1'b1, rx, extra);
      check("same_pre_done", {31'd0, spi_done}, 32'd1);
      exp_q.push_back(32'h4444_4444);
      xfer(32'h4444_4444, 32, 1'b1, 1'b1, rx, extra);
      check("same_done", {31'd0, spi_done}, 32'd1);
      check("same_ovr",  {31'd0, spi_ovr},  32'd0);
      check("same_spi_o", spi_o, 32'h4444_4444);
      do_ack();

      // 40 SCLK cycles in one window: only the first 32 count.
      spi_i = 32'hFFFF_FFFF;
      exp_q.push_back(32'h89AB_CDEF);
      xfer(32'h89AB_CDEF, 40, 1'b0, 1'b1, rx, extra);
      check("extra_miso_word", rx, 32'hFFFF_FFFF);
      check("extra_miso_ones", extra, 32'd0);
      check("extra_spi_o", spi_o, 32'h89AB_CDEF);
      check("extra_ovr", {31'd0, spi_ovr}, 32'd0);
      do_ack();

      // Reset in the middle of a frame at bit 20.
      spi_i = 32'h1234_5678;
      xfer(32'hCAFE_F00D, 20, 1'b0, 1'b0, rx, extra);
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("midrst");
      cs   = 1'b1;
      sclk = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("midrst_no_abort", abort_cnt, 32'd1);
      check("midrst_oe", {31'd0, miso_oe}, 32'd0);
      spi_i = 32'h0BAD_F00D;
      exp_q.push_back(32'hDEAD_BEEF);
      xfer(32'hDEAD_BEEF, 32, 1'b0, 1'b1, rx, extra);
      check("midrst_miso_word", rx, 32'h0BAD_F00D);
      check("midrst_done", {31'd0, spi_done}, 32'd1);
      do_ack();

      repeat (5) @(negedge clk);
      check("queue_empty", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter FRAME_BITS, default 32, bits per SPI frame; legal range 8..32.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on SCLK, MOSI and CS inputs; minimum 2.
REQ-003 BOARD_CLOCK  in  1  sole clock for all logic, 40 MHz nominal.
REQ-004 RST  in  1  asynchronous, active-low reset.
REQ-005 SPI_SCLK  in  1  SPI clock from the external master; mode 0 (CPOL=0, CPHA=0).
REQ-006 SPI_MOSI  in  1  serial data from the master, MSB first.
REQ-007 SPI_CS  in  1  chip select, active-low.
REQ-008 SPI_MISO  out  1  serial data to the master, MSB first.
REQ-009 SPI_MISO_OE  out  1  MISO output enable, high only while selected.
REQ-010 SPI_I  in  FRAME_BITS  transmit word, captured at frame start.
REQ-011 SPI_O  out  FRAME_BITS  last complete received word.
REQ-012 SPI_DONE_O  out  1  receive-valid level, held until acknowledged.
REQ-013 SPI_ACK_I  in  1  one-cycle consume strobe for SPI_O.
REQ-014 SPI_OVR_O  out  1  sticky overrun flag.
REQ-015 SPI_ABORT_O  out  1  one-cycle pulse when a frame is cut short.

Function
REQ-016 SCLK, MOSI and CS shall pass through SYNC_STAGES flops, then through an edge detector that is one register deep.
REQ-017 The SCLK high and low times shall each be at least 4 BOARD_CLOCK periods; faster SCLK is unsupported.
REQ-018 The FSM shall have three states: IDLE, SHIFT and HOLD.
REQ-019 IDLE to SHIFT on a synchronized CS falling edge: capture SPI_I into the TX shift register, clear the bit counter, drive SPI_MISO with the TX MSB, and assert SPI_MISO_OE in the same cycle.
REQ-020 In SHIFT, each synchronized SCLK rising edge shall shift MOSI into the RX register LSB and increment the bit counter.
REQ-021 In SHIFT, each synchronized SCLK falling edge shall shift the TX register left and present the next bit on SPI_MISO.
REQ-022 On the rising edge that completes bit FRAME_BITS, the block shall load SPI_O with the RX word in the next cycle, set SPI_DONE_O, and go to HOLD.
REQ-023 In HOLD, further SCLK edges shall be ignored and SPI_MISO shall be 0.
REQ-024 HOLD to IDLE on a CS rising edge.
REQ-025 A CS rising edge in SHIFT with fewer than FRAME_BITS bits received shall pulse SPI_ABORT_O for one cycle, leave SPI_O and SPI_DONE_O unchanged, and go to IDLE.
REQ-026 SPI_ACK_I shall clear SPI_DONE_O and SPI_OVR_O the next cycle; an ACK while SPI_DONE_O is low is a no-op.
REQ-027 A frame completing while SPI_DONE_O is high shall overwrite SPI_O and set SPI_OVR_O.
REQ-028 If a frame completes in the same cycle as SPI_ACK_I, SPI_DONE_O shall stay high with the new word and SPI_OVR_O shall stay clear.
REQ-029 SPI_MISO_OE shall be low in IDLE and high in SHIFT and HOLD, deasserting the cycle after CS rises.
REQ-030 The bit counter shall be ceil(log2(FRAME_BITS+1)) bits wide and shall never wrap; it saturates at FRAME_BITS.

Reset
REQ-031 With RST low, the state shall be IDLE, all shift registers and counters 0, and all synchronizer flops at their idle levels (SCLK 0, CS 1).
REQ-032 Reset values: SPI_O=0, SPI_DONE_O=0, SPI_OVR_O=0, SPI_ABORT_O=0, SPI_MISO=0, SPI_MISO_OE=0.
REQ-033 Reset asserted mid-frame shall discard the frame with no ABORT pulse; after release, the block shall wait for a fresh CS falling edge.

Structure
REQ-034 FRAME_BITS default, the FSM state encodings and the synchronizer idle levels shall live in a shared package, spi_defs.
REQ-035 The synchronizer plus edge detector shall be one sub-module, spi_sync_edge, instantiated once per input.

Verification
REQ-036 32-bit frame: SPI_I=0xA5C3_0F81, master sends 0x1234_5678 at 2.5 MHz -> master reads 0xA5C3_0F81 on MISO; SPI_O=0x1234_5678; SPI_DONE_O high until ACK.
REQ-037 Abort: CS rises after 13 bits -> one-cycle SPI_ABORT_O pulse; SPI_O keeps its previous value; SPI_DONE_O unchanged; next full frame received correctly.
REQ-038 Overrun: two frames 0x1111_1111 then 0x2222_2222 with no ACK -> SPI_O=0x2222_2222 and SPI_OVR_O=1; ACK clears both flags.
REQ-039 Frame completion and SPI_ACK_I in the same cycle -> SPI_DONE_O=1, SPI_OVR_O=0, SPI_O holds the new word.
REQ-040 Extra clocks: 40 SCLK cycles in one CS window -> only the first 32 bits captured; SPI_MISO=0 for bits 33..40.
REQ-041 RST pulsed low at bit 20 -> all outputs at reset values, no ABORT pulse; next frame 0xDEAD_BEEF received intact.
